// File: rtl/mem_responder.sv
// Word-addressed data memory answering single/burst loads and stores; one ack per beat, WAIT_CYCLES+1 cycles per beat.
// No backpressure: requests are sampled only while idle, and any request seen while busy is dropped.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 1,
    parameter int BURST_LEN   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic              req_burst,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              ack,
    output logic [DATA_W-1:0] rdata,
    output logic              done,
    output logic [2:0]        beat
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER} state_t;

    localparam int                WCNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
    localparam logic [2:0]        BEAT_LAST = 3'(BURST_LEN - 1);
    localparam state_t            BEAT_ENTRY = (WAIT_CYCLES == 0) ? S_XFER : S_WAIT;

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state_q, state_d;
    logic              wr_q, wr_d;
    logic              burst_q, burst_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [2:0]        beat_cnt_q, beat_cnt_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              done_q, done_d;
    logic [2:0]        beat_q, beat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              last_beat;

    assign last_beat = !burst_q || (beat_cnt_q == BEAT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid) state_d = BEAT_ENTRY;
            S_WAIT:  if (wait_cnt_q == WAIT_LAST) state_d = S_XFER;
            S_XFER:  state_d = last_beat ? S_IDLE : BEAT_ENTRY;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_d       = wr_q;
        burst_d    = burst_q;
        addr_d     = addr_q;
        beat_cnt_d = beat_cnt_q;
        wait_cnt_d = wait_cnt_q;
        ack_d      = 1'b0;
        done_d     = 1'b0;
        beat_d     = beat_q;
        rdata_d    = rdata_q;
        busy_d     = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    wr_d       = req_write;
                    burst_d    = req_burst;
                    addr_d     = req_addr;
                    beat_cnt_d = 3'd0;
                    wait_cnt_d = '0;
                end
            end
            S_WAIT: begin
                wait_cnt_d = (wait_cnt_q == WAIT_LAST) ? '0 : wait_cnt_q + WCNT_W'(1);
            end
            S_XFER: begin
                ack_d  = 1'b1;
                done_d = last_beat;
                beat_d = beat_cnt_q;
                if (!wr_q) rdata_d = mem[addr_q];
                if (!last_beat) begin
                    // Address wraps silently at the top of the array.
                    addr_d     = addr_q + ADDR_W'(1);
                    beat_cnt_d = beat_cnt_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q       <= 1'b0;
            burst_q    <= 1'b0;
            addr_q     <= '0;
            beat_cnt_q <= 3'd0;
            wait_cnt_q <= '0;
            busy_q     <= 1'b0;
            ack_q      <= 1'b0;
            done_q     <= 1'b0;
            beat_q     <= 3'd0;
            rdata_q    <= '0;
        end else begin
            wr_q       <= wr_d;
            burst_q    <= burst_d;
            addr_q     <= addr_d;
            beat_cnt_q <= beat_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            busy_q     <= busy_d;
            ack_q      <= ack_d;
            done_q     <= done_d;
            beat_q     <= beat_d;
            rdata_q    <= rdata_d;
        end
    end

    // Array is never reset; an aborted burst stops writing because reset forces state_q to IDLE.
    always_ff @(posedge clk) begin
        if (state_q == S_XFER && wr_q) mem[addr_q] <= wdata;
    end

    assign busy  = busy_q;
    assign ack   = ack_q;
    assign done  = done_q;
    assign beat  = beat_q;
    assign rdata = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: instance 0 runs WAIT_CYCLES=1, instance 1 runs WAIT_CYCLES=0; sel steers requests/outputs.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n, sel;
    logic        req_valid, req_write, req_burst;
    logic [7:0]  req_addr;
    logic [15:0] wdata;

    logic        busy0, ack0, done0, busy1, ack1, done1;
    logic [15:0] rdata0, rdata1;
    logic [2:0]  beat0, beat1;

    logic        busy, ack, done;
    logic [15:0] rdata;
    logic [2:0]  beat;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [15:0] model [2][256];
    logic [15:0] exp_rdata [2];

    always #5 clk = ~clk;

    assign busy  = sel ? busy1  : busy0;
    assign ack   = sel ? ack1   : ack0;
    assign done  = sel ? done1  : done0;
    assign rdata = sel ? rdata1 : rdata0;
    assign beat  = sel ? beat1  : beat0;

    mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(1), .BURST_LEN(8)) u_dut_w1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & ~sel), .req_write(req_write),
        .req_burst(req_burst), .req_addr(req_addr), .wdata(wdata),
        .busy(busy0), .ack(ack0), .rdata(rdata0), .done(done0), .beat(beat0)
    );

    mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_CYCLES(0), .BURST_LEN(8)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid & sel), .req_write(req_write),
        .req_burst(req_burst), .req_addr(req_addr), .wdata(wdata),
        .busy(busy1), .ack(ack1), .rdata(rdata1), .done(done1), .beat(beat1)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic do_req(input logic wr, input logic bst, input logic [7:0] addr, input logic [15:0] d0);
        req_valid = 1'b1;
        req_write = wr;
        req_burst = bst;
        req_addr  = addr;
        wdata     = d0;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = ~wr;
        req_burst = ~bst;
        req_addr  = ~addr;
        check_eq("busy_after_accept", busy, 1);
    endtask

    // Runs one transaction, checking every cycle; returns at the negedge of the final ack (or stop_c).
    task automatic run_burst(input int w, input logic wr, input logic bst, input logic [7:0] addr,
                             input logic [15:0] base, input int poke_c, input int stop_c);
        int          nb     = bst ? 8 : 1;
        int          stride = w + 1;
        int          s;
        int          b;
        logic [7:0]  a;
        s = sel ? 1 : 0;
        do_req(wr, bst, addr, base);
        for (int c = 1; c <= nb * stride; c++) begin
            @(negedge clk);
            req_valid = (c == poke_c);
            if (c % stride == 0) begin
                b = c / stride - 1;
                a = addr + 8'(b);
                check_eq("ack_on_beat", ack, 1);
                check_eq("beat_index", beat, b);
                check_eq("done_on_last", done, (b == nb - 1) ? 1 : 0);
                if (wr) begin
                    model[s][a] = base + 16'(b);
                    wdata       = base + 16'(b + 1);
                end else begin
                    exp_rdata[s] = model[s][a];
                end
                check_eq("rdata_beat", rdata, exp_rdata[s]);
            end else begin
                check_eq("ack_idle_gap", ack, 0);
                check_eq("done_idle_gap", done, 0);
            end
            check_eq("busy_during", busy, (c < nb * stride) ? 1 : 0);
            if (c == stop_c) return;
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("no_extra_ack", ack, 0);
            check_eq("idle_not_busy", busy, 0);
        end
    endtask

    initial begin
        sel          = 1'b0;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_burst    = 1'b0;
        req_addr     = 8'h00;
        wdata        = 16'h0000;
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;

        @(negedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_rdata", rdata, 0);
        check_eq("rst_beat", beat, 0);
        check_eq("rst_busy_w0", busy1, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single write then read, WAIT_CYCLES=1.
        run_burst(1, 1'b1, 1'b0, 8'h10, 16'hBEEF, 0, 0);
        idle_check(2);
        run_burst(1, 1'b0, 1'b0, 8'h10, 16'h0000, 0, 0);
        check_eq("single_rd_data", rdata, 16'hBEEF);
        idle_check(2);

        // Burst write across the top of the array, with a request poked during beat 2.
        run_burst(1, 1'b1, 1'b1, 8'hFC, 16'h1000, 5, 0);
        idle_check(6);

        // Back-to-back: read issued in the final-ack cycle of a write.
        run_burst(1, 1'b1, 1'b0, 8'h80, 16'h1234, 0, 0);
        run_burst(1, 1'b0, 1'b0, 8'h00, 16'h0000, 0, 0);
        check_eq("b2b_rd_wrapped", rdata, 16'h1004);
        idle_check(1);

        run_burst(1, 1'b0, 1'b1, 8'hFC, 16'h0000, 0, 0);
        check_eq("burst_rd_last", rdata, 16'h1007);
        idle_check(1);

        // Reset mid-burst: preload 0x20..0x27, then abort a new burst after beat 3.
        run_burst(1, 1'b1, 1'b1, 8'h20, 16'h5500, 0, 0);
        idle_check(1);
        run_burst(1, 1'b1, 1'b1, 8'h20, 16'h2000, 0, 8);
        rst_n = 1'b0;
        #1;
        check_eq("abort_ack", ack, 0);
        check_eq("abort_beat", beat, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_rdata", rdata, 0);
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_check(2);
        run_burst(1, 1'b0, 1'b1, 8'h20, 16'h0000, 0, 0);
        check_eq("abort_kept_old", rdata, 16'h5507);
        idle_check(1);
        run_burst(1, 1'b0, 1'b0, 8'h23, 16'h0000, 0, 0);
        check_eq("abort_new_beat3", rdata, 16'h2003);
        idle_check(1);

        // WAIT_CYCLES=0 instance: consecutive acks, busy for exactly 8 cycles.
        sel = 1'b1;
        idle_check(1);
        run_burst(0, 1'b1, 1'b1, 8'h40, 16'h3000, 0, 0);
        run_burst(0, 1'b0, 1'b1, 8'h40, 16'h0000, 0, 0);
        check_eq("w0_rd_last", rdata, 16'h3007);
        idle_check(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multicycle RISC core's load/store path. It accepts single-word and burst (LM/SM-style, one word per register) read/write requests from the controller/datapath, applies a programmable number of wait states per beat, and returns one acknowledge per beat with read data. It holds the word-addressed data memory array.

## Interface
- `DATA_W`, 16: data word width.
- `ADDR_W`, 8: word-address width; memory depth is 2^ADDR_W words.
- `WAIT_CYCLES`, 1: wait states inserted before every beat; 0 is legal.
- `BURST_LEN`, 8: beats per burst request; range 2..8.

- `clk`  in  1: clock, rising-edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: request strobe, sampled only while `busy`=0.
- `req_write`  in  1: 1 = write, 0 = read.
- `req_burst`  in  1: 1 = `BURST_LEN` consecutive words, 0 = single word.
- `req_addr`  in  ADDR_W: start word address.
- `wdata`  in  DATA_W: write data for the current beat; held stable by the initiator until that beat's `ack`.
- `busy`  out  1: transaction in progress; requests ignored.
- `ack`  out  1: one-cycle pulse per completed beat.
- `rdata`  out  DATA_W: read data, valid while `ack`=1 on a read.
- `done`  out  1: one-cycle pulse coincident with the final beat's `ack`.
- `beat`  out  3: index of the beat that `ack` reports, 0..BURST_LEN-1.

## Operation
- FSM states are IDLE, WAIT, and XFER.
- **IDLE**
  - On `req_valid`=1, latch `req_write`, `req_burst` and `req_addr` into the address register, and clear the beat counter.
  - Go to WAIT, or to XFER if `WAIT_CYCLES`=0.
- **WAIT**
  - The wait counter runs for exactly `WAIT_CYCLES` cycles, then the FSM goes to XFER.
- **XFER** lasts one cycle. On the exiting edge:
  - Write: `mem[addr] <= wdata`.
  - Read: `rdata <= mem[addr]`.
  - `ack <= 1` and `beat <= beat counter`.
  - If this is the last beat (single request, or counter = `BURST_LEN`-1): `done <= 1` and go to IDLE.
  - Otherwise: address increments, counter increments, and the FSM goes to WAIT (or directly to XFER if `WAIT_CYCLES`=0).
- Address increment wraps modulo 2^ADDR_W (0xFF+1 → 0x00 at `ADDR_W`=8). Wrap is silent, with no error.
- `busy` is registered and equals (state ≠ IDLE). It is therefore 0 in the cycle carrying the final `ack`.
- A `req_valid` present in that final-ack cycle is accepted (back-to-back transactions).
- `req_valid` while `busy`=1 is dropped, not queued. `req_*` changes during a transaction have no effect.
- `rdata` holds its last value outside `ack` cycles. Writes leave `rdata` unchanged.
- The memory array is not reset; its contents survive `rst_n`.

## Timing
- **Reset values:** asserting `rst_n` low asynchronously forces state IDLE, `busy`=0, `ack`=0, `done`=0, `rdata`=0, `beat`=0, and clears the counters.
- **Reset mid-transaction:** the transaction aborts immediately. No further memory write occurs, and beats already written remain in memory.
- **Acceptance:** at rising edge E0 with `busy`=0 and `req_valid`=1. `busy`=1 from the cycle after E0.
- **Per-beat latency:** `ack` is high in the cycle after edge E0+`WAIT_CYCLES`+1. This is 2 cycles after acceptance for `WAIT_CYCLES`=1.
- **Beat spacing:** consecutive burst beats have their `ack`s spaced `WAIT_CYCLES`+1 cycles apart.
- **Total latency:** a burst completes `BURST_LEN`×(`WAIT_CYCLES`+1) edges after E0.
- **Write data:** `wdata` is sampled on the XFER-exit edge. The initiator presents beat n+1 data in the cycle after beat n's `ack`. This is guaranteed in time only for `WAIT_CYCLES`≥1; with `WAIT_CYCLES`=0 the initiator must present beat n+1 data combinationally on `ack`.
- **Outputs:** all outputs are registered.

## Test plan
- **Single write then read (`WAIT_CYCLES`=1):** write 0xBEEF to addr 0x10, then read addr 0x10 → `ack` 2 cycles after each acceptance, `done`=`ack`, `rdata`=0xBEEF, `beat`=0.
- **Burst write with wrap:** start addr 0xFC, data 0x1000..0x1007 → 8 `ack`s spaced 2 cycles apart, `done` on `beat`=7, words land at 0xFC..0xFF and 0x00..0x03. A following burst read from 0xFC returns 0x1000..0x1007 in order.
- **Request while busy:** a read request is pulsed during the third beat of a burst → it is ignored, and no extra `ack` appears after `done`.
- **Back-to-back:** a new read request is asserted in the final-ack cycle of a write → it is accepted on that edge, and its `ack` arrives 2 cycles later.
- **Reset mid-burst:** `rst_n` is driven low after beat 3 of an 8-word write to 0x20 → outputs go to 0 asynchronously. Afterwards addr 0x20..0x23 hold the new data and 0x24..0x27 are unchanged.
- **`WAIT_CYCLES`=0:** a burst read completes in 8 consecutive `ack` cycles, with `busy` high for exactly 8 cycles.
